// File: rtl/core_seq_pkg.sv
// Shared types and constants for the RV32I multi-cycle core sequencer.
package core_seq_pkg;

  typedef enum logic [2:0] {
    StFetchReq,
    StFetchWait,
    StDecode,
    StExecute,
    StWriteback,
    StHalt
  } seq_state_e;

  localparam logic [31:0] Nop    = 32'h0000_0013;
  localparam logic [31:0] PcStep = 32'd4;
  localparam int unsigned RdMsb  = 11;
  localparam int unsigned RdLsb  = 7;

endpackage

// File: rtl/core_seq_perf_counters.sv
// Cycle and retired-instruction counters for the core sequencer; both wrap at 2^32.
module core_seq_perf_counters
  import core_seq_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        retire,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  logic [31:0] cycle_q, instret_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (retire) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the RV32I minimum core.
// Define SEQ_PERF_COUNTERS_EN to build the cycle/instret performance counters.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic        decode_illegal,
  input  logic        rd_write_request,
  input  logic        next_pc_valid,
  input  logic [31:0] next_pc,
  output logic        register_file_write_enable,
  output logic        halted,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  localparam logic [3:0] ExecLoad = 4'(EXEC_CYCLES - 1);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [3:0]  exec_cnt_q, exec_cnt_d;
  logic        misaligned;
  logic        retire;

  assign misaligned = next_pc_valid && (next_pc[1:0] != 2'b00);
  assign retire     = (state_q == StWriteback) && !misaligned;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    exec_cnt_d = exec_cnt_q;
    unique case (state_q)
      StFetchReq: begin
        if (imem_req_ready) state_d = StFetchWait;
      end
      StFetchWait: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (decode_illegal) begin
          state_d = StHalt;
        end else begin
          exec_cnt_d = ExecLoad;
          state_d    = StExecute;
        end
      end
      StExecute: begin
        if (exec_cnt_q == 4'd0) state_d = StWriteback;
        else exec_cnt_d = exec_cnt_q - 4'd1;
      end
      StWriteback: begin
        // A misaligned redirect stops the core without committing anything.
        if (misaligned) begin
          state_d = StHalt;
        end else begin
          pc_d    = next_pc_valid ? next_pc : pc_q + PcStep;
          state_d = StFetchReq;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StFetchReq;
      pc_q       <= RESET_PC;
      instr_q    <= Nop;
      exec_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      exec_cnt_q <= exec_cnt_d;
    end
  end

  assign imem_req_valid = (state_q == StFetchReq);
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign instruction    = instr_q;
  assign halted         = (state_q == StHalt);

  // Qualified by the writeback state so the strobe cannot leak into other states.
  assign register_file_write_enable = retire && rd_write_request &&
                                      (instr_q[RdMsb:RdLsb] != 5'd0);

`ifdef SEQ_PERF_COUNTERS_EN
  core_seq_perf_counters u_perf_counters (
    .clock         (clock),
    .reset         (reset),
    .retire        (retire),
    .cycle_count   (cycle_count),
    .instret_count (instret_count)
  );
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign cycle_count   = '0;
  assign instret_count = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed, table-driven bench for core_sequencer.
module tb_core_sequencer;

  localparam int unsigned ExecCycles = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        decode_illegal;
  logic        rd_write_request;
  logic        next_pc_valid;
  logic [31:0] next_pc;
  logic        register_file_write_enable;
  logic        halted;
  logic [31:0] cycle_count;
  logic [31:0] instret_count;

  core_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .EXEC_CYCLES (ExecCycles)
  ) dut (
    .clock                      (clock),
    .reset                      (reset),
    .imem_req_valid             (imem_req_valid),
    .imem_req_ready             (imem_req_ready),
    .imem_addr                  (imem_addr),
    .imem_rsp_valid             (imem_rsp_valid),
    .imem_rsp_data              (imem_rsp_data),
    .instruction                (instruction),
    .pc                         (pc),
    .decode_illegal             (decode_illegal),
    .rd_write_request           (rd_write_request),
    .next_pc_valid              (next_pc_valid),
    .next_pc                    (next_pc),
    .register_file_write_enable (register_file_write_enable),
    .halted                     (halted),
    .cycle_count                (cycle_count),
    .instret_count              (instret_count)
  );

  always #5 clock = ~clock;

`ifdef SEQ_PERF_COUNTERS_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        illegal;
    logic        rd_wr;
    logic        npv;
    logic [31:0] npc;
    logic        exp_wr;
    logic [31:0] exp_pc;
    logic        exp_halt;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    imem_req_ready   = 1'b0;
    imem_rsp_valid   = 1'b0;
    imem_rsp_data    = 32'h0;
    decode_illegal   = 1'b0;
    rd_write_request = 1'b0;
    next_pc_valid    = 1'b0;
    next_pc          = 32'h0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Walks one instruction through fetch/decode/execute/writeback with zero-wait memory.
  task automatic run_instr(input vec_t v);
    chk("fetch_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("fetch_addr", imem_addr, v.addr);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = v.instr;
    step();
    clear_inputs();
    chk("latched_instr", instruction, v.instr);
    decode_illegal = v.illegal;
    step();
    decode_illegal = 1'b0;
    if (v.illegal) begin
      chk("illegal_halted", {31'd0, halted}, 32'd1);
      chk("illegal_pc", pc, v.addr);
      return;
    end
    rd_write_request = 1'b1;
    for (int c = 0; c < int'(ExecCycles); c++) begin
      chk("exec_wr_en", {31'd0, register_file_write_enable}, 32'd0);
      step();
    end
    rd_write_request = v.rd_wr;
    next_pc_valid    = v.npv;
    next_pc          = v.npc;
    #1;
    chk("wb_wr_en", {31'd0, register_file_write_enable}, {31'd0, v.exp_wr});
    step();
    clear_inputs();
    chk("wb_pc", pc, v.exp_pc);
    chk("wb_halted", {31'd0, halted}, {31'd0, v.exp_halt});
  endtask

  initial begin
    logic [31:0] cyc_before;

    // addr, instr, illegal, rd_wr, npv, npc, exp_wr, exp_pc, exp_halt
    tbl[0] = '{32'h0000_0000, 32'h0010_0093, 1'b0, 1'b1, 1'b0, 32'h0,
               1'b1, 32'h0000_0004, 1'b0};
    tbl[1] = '{32'h0000_0004, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 32'h55,
               1'b0, 32'h0000_0008, 1'b0};
    tbl[2] = '{32'h0000_0008, 32'h0F80_00EF, 1'b0, 1'b1, 1'b1, 32'h100,
               1'b1, 32'h0000_0100, 1'b0};
    tbl[3] = '{32'h0000_0100, 32'h0011_2023, 1'b0, 1'b0, 1'b0, 32'h0,
               1'b0, 32'h0000_0104, 1'b0};
    tbl[4] = '{32'h0000_0104, 32'h0000_8067, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC,
               1'b0, 32'hFFFF_FFFC, 1'b0};
    tbl[5] = '{32'hFFFF_FFFC, 32'h0020_0113, 1'b0, 1'b1, 1'b0, 32'h0,
               1'b1, 32'h0000_0000, 1'b0};
    tbl[6] = '{32'h0000_0000, 32'h0000_0463, 1'b0, 1'b1, 1'b1, 32'h102,
               1'b0, 32'h0000_0000, 1'b1};

    apply_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instruction, 32'h0000_0013);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rst_wr_en", {31'd0, register_file_write_enable}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_cycle", cycle_count, 32'd0);
    chk("rst_instret", instret_count, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_instr(tbl[i]);
      if (i == 2) begin
        chk("perf_cycle_3", cycle_count, PerfEn ? 32'd15 : 32'd0);
        chk("perf_instret_3", instret_count, PerfEn ? 32'd3 : 32'd0);
      end
    end

    // Halted by misaligned redirect: nothing moves, only cycle_count keeps running.
    cyc_before     = cycle_count;
    imem_req_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("halt_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_pc", pc, 32'h0);
    end
    imem_req_ready = 1'b0;
    chk("halt_cycle_delta", cycle_count - cyc_before, PerfEn ? 32'd3 : 32'd0);
    chk("halt_instret", instret_count, PerfEn ? 32'd6 : 32'd0);

    // Ready stall with a stray response, then a late response and an illegal decode.
    apply_reset();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("stall_addr", imem_addr, 32'h0);
      chk("stall_instr", instruction, 32'h0000_0013);
    end
    clear_inputs();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    chk("late_rsp_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("late_rsp_instr", instruction, 32'h0000_0013);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hFFFF_FFFF;
    step();
    clear_inputs();
    chk("late_rsp_latched", instruction, 32'hFFFF_FFFF);
    decode_illegal = 1'b1;
    step();
    decode_illegal = 1'b0;
    chk("illegal_halted", {31'd0, halted}, 32'd1);
    chk("illegal_pc", pc, 32'h0);
    imem_req_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("illegal_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    clear_inputs();

    // Reset asserted while in EXECUTE abandons the instruction.
    apply_reset();
    run_instr(tbl[0]);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0030_0193;
    step();
    clear_inputs();
    step();
    rd_write_request = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("mid_rst_wr_en", {31'd0, register_file_write_enable}, 32'd0);
    step();
    reset = 1'b0;
    clear_inputs();
    chk("mid_rst_instr", instruction, 32'h0000_0013);
    run_instr(tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
